// File: rtl/sigmoid_divider_pkg.sv
// Shared types and width helpers for the sigmoid divider slice.
// The datapath widths are derived from the CORDIC width XY_SZ.
package sigmoid_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      DONE
   } state_t;

   localparam int XY_SZ_DEFAULT = 16;
   localparam int ONE           = 1 << (XY_SZ_DEFAULT - 2);
   localparam int STEP_W        = 5;

   // Divisor, remainder and quotient widths for a given datapath width
   function automatic int d_width(input int xy_sz);
      return xy_sz + 3;
   endfunction

   function automatic int r_width(input int xy_sz);
      return xy_sz + 4;
   endfunction

   function automatic int q_width(input int xy_sz);
      return xy_sz + 1;
   endfunction

   localparam int D_W = XY_SZ_DEFAULT + 3;
   localparam int R_W = XY_SZ_DEFAULT + 4;
   localparam int Q_W = XY_SZ_DEFAULT + 1;

endpackage

// File: rtl/sigmoid_divider_if.sv
// Valid/ready operand and result channels of the sigmoid divider.
// master drives operands and result acceptance; slave is the divider.
interface sigmoid_divider_if #(
   parameter int XY_SZ = 16
);

   logic               in_valid;
   logic               in_ready;
   logic [XY_SZ+1:0]   exp_in;
   logic               out_valid;
   logic               out_ready;
   logic [XY_SZ-1:0]   sig_out;

   modport master (
      output in_valid,
      output exp_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  sig_out
   );

   modport slave (
      input  in_valid,
      input  exp_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output sig_out
   );

endinterface

// File: rtl/sigmoid_divider_div_step.sv
// One restoring-division step: optional left shift of the remainder,
// trial subtract of the divisor, and the resulting quotient bit.
module div_step
   import sigmoid_pkg::*;
#(
   parameter int XY_SZ = 16
) (
   input  logic [r_width(XY_SZ)-1:0] r,
   input  logic [d_width(XY_SZ)-1:0] d,
   input  logic                      shift_en,
   output logic [r_width(XY_SZ)-1:0] r_next,
   output logic                      q_bit
);

   localparam int RW = r_width(XY_SZ);

   logic [RW-1:0] r_shift;
   logic [RW-1:0] d_ext;

   // R stays below D between steps, so the shifted value never loses its MSB
   always_comb begin
      r_shift = shift_en ? {r[RW-2:0], 1'b0} : r;
      d_ext   = {1'b0, d};
      q_bit   = (r_shift >= d_ext);
      r_next  = q_bit ? (r_shift - d_ext) : r_shift;
   end

endmodule

// File: rtl/sigmoid_divider.sv
// Logistic sigmoid back end: sig = 2^(FRAC+XY_SZ) / (2^FRAC + e^-x),
// computed by a bit-serial restoring divider, one quotient bit per cycle.
module sigmoid_divider
   import sigmoid_pkg::*;
#(
   parameter int XY_SZ = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sigmoid_divider_if.slave     bus
);

   localparam int FRAC = XY_SZ - 2;
   localparam int DW   = d_width(XY_SZ);
   localparam int RW   = r_width(XY_SZ);
   localparam int QW   = q_width(XY_SZ);

   localparam logic [DW-1:0]     D_ONE     = {{(DW-1){1'b0}}, 1'b1} << FRAC;
   localparam logic [RW-1:0]     R_ONE     = {{(RW-1){1'b0}}, 1'b1} << FRAC;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(XY_SZ);

   state_t              state, state_next;
   logic [DW-1:0]       d_reg, d_next;
   logic [RW-1:0]       r_reg, r_next;
   logic [QW-1:0]       q_reg, q_next, q_shift;
   logic [STEP_W-1:0]   step_reg, step_next;
   logic [XY_SZ-1:0]    sig_reg, sig_next;
   logic [RW-1:0]       step_r;
   logic                step_bit;

   div_step #(
      .XY_SZ(XY_SZ)
   ) u_div_step (
      .r        (r_reg),
      .d        (d_reg),
      .shift_en (step_reg != '0),
      .r_next   (step_r),
      .q_bit    (step_bit)
   );

   // State and datapath registers; reset discards any division in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         d_reg    <= '0;
         r_reg    <= '0;
         q_reg    <= '0;
         step_reg <= '0;
         sig_reg  <= '0;
      end else begin
         state    <= state_next;
         d_reg    <= d_next;
         r_reg    <= r_next;
         q_reg    <= q_next;
         step_reg <= step_next;
         sig_reg  <= sig_next;
      end
   end

   // Next-state and handshake logic; the result saturates when Q reaches 2^XY_SZ
   always_comb begin
      state_next    = state;
      d_next        = d_reg;
      r_next        = r_reg;
      q_next        = q_reg;
      step_next     = step_reg;
      sig_next      = sig_reg;
      q_shift       = {q_reg[QW-2:0], step_bit};
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);

      case (state)
         IDLE: begin
            if (bus.in_valid) begin
               d_next     = D_ONE + {1'b0, bus.exp_in};
               r_next     = R_ONE;
               q_next     = '0;
               step_next  = '0;
               state_next = DIV;
            end
         end
         DIV: begin
            r_next    = step_r;
            q_next    = q_shift;
            step_next = step_reg + STEP_W'(1);
            if (step_reg == LAST_STEP) begin
               state_next = DONE;
               sig_next   = q_shift[XY_SZ] ? '1 : q_shift[XY_SZ-1:0];
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.sig_out = sig_reg;

endmodule
